// File: rtl/src_ctrl_pkg.sv
// Shared opcodes, ALU selects, FSM states and the control-word bundle for the
// Mini SRC hardwired control unit.
package src_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_SHR  = 5'd7;
    localparam logic [4:0] OP_SHRA = 5'd8;
    localparam logic [4:0] OP_SHL  = 5'd9;
    localparam logic [4:0] OP_ROR  = 5'd10;
    localparam logic [4:0] OP_ROL  = 5'd11;
    localparam logic [4:0] OP_ADDI = 5'd12;
    localparam logic [4:0] OP_ANDI = 5'd13;
    localparam logic [4:0] OP_ORI  = 5'd14;
    localparam logic [4:0] OP_MUL  = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16;
    localparam logic [4:0] OP_NEG  = 5'd17;
    localparam logic [4:0] OP_NOT  = 5'd18;
    localparam logic [4:0] OP_BR   = 5'd19;
    localparam logic [4:0] OP_JR   = 5'd20;
    localparam logic [4:0] OP_JAL  = 5'd21;
    localparam logic [4:0] OP_IN   = 5'd22;
    localparam logic [4:0] OP_OUT  = 5'd23;
    localparam logic [4:0] OP_MFHI = 5'd24;
    localparam logic [4:0] OP_MFLO = 5'd25;
    localparam logic [4:0] OP_NOP  = 5'd26;
    localparam logic [4:0] OP_HALT = 5'd27;

    localparam logic [4:0] ALU_ADD = OP_ADD;
    localparam logic [4:0] ALU_AND = OP_AND;
    localparam logic [4:0] ALU_OR  = OP_OR;

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_WAIT, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_NOP, C_RTYPE, C_ITYPE, C_UNARY, C_LDI, C_LD, C_ST, C_MULDIV,
        C_BR, C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_HALT
    } op_class_t;

    typedef struct packed {
        logic       gra, grb, grc, rin, rout, ba_out;
        logic       pc_out, mdr_out, zhi_out, zlo_out, hi_out, lo_out, c_out, inport_out;
        logic       pc_en, pc_inc, ir_en, mar_en, mdr_en, y_en, zhi_en, zlo_en;
        logic       hi_en, lo_en, outport_en, con_in;
        logic       read, write;
        logic [4:0] alu_control;
        logic       running;
    } ctrl_out_t;

    function automatic op_class_t op_class(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL:
                return C_RTYPE;
            OP_ADDI, OP_ANDI, OP_ORI: return C_ITYPE;
            OP_NEG, OP_NOT:           return C_UNARY;
            OP_LDI:                   return C_LDI;
            OP_LD:                    return C_LD;
            OP_ST:                    return C_ST;
            OP_MUL, OP_DIV:           return C_MULDIV;
            OP_BR:                    return C_BR;
            OP_JR:                    return C_JR;
            OP_JAL:                   return C_JAL;
            OP_IN:                    return C_IN;
            OP_OUT:                   return C_OUT;
            OP_MFHI:                  return C_MFHI;
            OP_MFLO:                  return C_MFLO;
            OP_HALT:                  return C_HALT;
            default:                  return C_NOP;
        endcase
    endfunction

    // Final execute step of each class; the FSM leaves for the boundary after it.
    function automatic state_t last_step(input op_class_t cls);
        case (cls)
            C_RTYPE, C_ITYPE, C_LDI: return S_T5;
            C_UNARY, C_JAL:          return S_T4;
            C_LD, C_ST:              return S_T7;
            C_MULDIV, C_BR:          return S_T6;
            default:                 return S_T3;
        endcase
    endfunction

    function automatic logic [4:0] imm_alu(input logic [4:0] op);
        case (op)
            OP_ANDI: return ALU_AND;
            OP_ORI:  return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational control-word decode: (state, opcode, con_ff) -> every datapath
// strobe. Only one bus source is ever asserted per step.
module ctrl_decode
    import src_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [4:0] opcode,
    input  logic       con_ff,
    output ctrl_out_t  ctl
);

    op_class_t w_cls;

    assign w_cls = op_class(opcode);

    always_comb begin
        ctl         = '0;
        ctl.running = (state != S_HALT);
        case (state)
            S_T0: begin
                ctl.pc_out = 1'b1; ctl.mar_en = 1'b1; ctl.pc_inc = 1'b1;
                ctl.zlo_en = 1'b1; ctl.alu_control = ALU_ADD;
            end
            S_T1: begin
                ctl.zlo_out = 1'b1; ctl.pc_en = 1'b1; ctl.read = 1'b1; ctl.mdr_en = 1'b1;
            end
            S_T2: begin
                ctl.mdr_out = 1'b1; ctl.ir_en = 1'b1;
            end
            S_T3: begin
                case (w_cls)
                    C_RTYPE, C_ITYPE: begin ctl.grb = 1'b1; ctl.rout = 1'b1; ctl.y_en = 1'b1; end
                    C_UNARY: begin
                        ctl.grb = 1'b1; ctl.rout = 1'b1; ctl.zlo_en = 1'b1; ctl.alu_control = opcode;
                    end
                    C_LDI, C_LD, C_ST: begin
                        ctl.grb = 1'b1; ctl.rout = 1'b1; ctl.ba_out = 1'b1; ctl.y_en = 1'b1;
                    end
                    C_MULDIV: begin ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.y_en = 1'b1; end
                    C_BR:     begin ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.con_in = 1'b1; end
                    C_JR:     begin ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.pc_en = 1'b1; end
                    C_JAL:    begin ctl.pc_out = 1'b1; ctl.grb = 1'b1; ctl.rin = 1'b1; end
                    C_IN:     begin ctl.inport_out = 1'b1; ctl.gra = 1'b1; ctl.rin = 1'b1; end
                    C_OUT:    begin ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.outport_en = 1'b1; end
                    C_MFHI:   begin ctl.hi_out = 1'b1; ctl.gra = 1'b1; ctl.rin = 1'b1; end
                    C_MFLO:   begin ctl.lo_out = 1'b1; ctl.gra = 1'b1; ctl.rin = 1'b1; end
                    default: ;
                endcase
            end
            S_T4: begin
                case (w_cls)
                    C_RTYPE: begin
                        ctl.grc = 1'b1; ctl.rout = 1'b1; ctl.zlo_en = 1'b1; ctl.alu_control = opcode;
                    end
                    C_ITYPE: begin
                        ctl.c_out = 1'b1; ctl.zlo_en = 1'b1; ctl.alu_control = imm_alu(opcode);
                    end
                    C_UNARY: begin ctl.zlo_out = 1'b1; ctl.gra = 1'b1; ctl.rin = 1'b1; end
                    C_LDI, C_LD, C_ST: begin
                        ctl.c_out = 1'b1; ctl.zlo_en = 1'b1; ctl.alu_control = ALU_ADD;
                    end
                    C_MULDIV: begin
                        ctl.grb = 1'b1; ctl.rout = 1'b1; ctl.zlo_en = 1'b1; ctl.zhi_en = 1'b1;
                        ctl.alu_control = opcode;
                    end
                    C_BR:  begin ctl.pc_out = 1'b1; ctl.y_en = 1'b1; end
                    C_JAL: begin ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.pc_en = 1'b1; end
                    default: ;
                endcase
            end
            S_T5: begin
                case (w_cls)
                    C_RTYPE, C_ITYPE, C_LDI: begin ctl.zlo_out = 1'b1; ctl.gra = 1'b1; ctl.rin = 1'b1; end
                    C_LD, C_ST: begin ctl.zlo_out = 1'b1; ctl.mar_en = 1'b1; end
                    C_MULDIV:   begin ctl.zlo_out = 1'b1; ctl.lo_en = 1'b1; end
                    C_BR: begin
                        ctl.c_out = 1'b1; ctl.zlo_en = 1'b1; ctl.alu_control = ALU_ADD;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (w_cls)
                    C_LD:     begin ctl.read = 1'b1; ctl.mdr_en = 1'b1; end
                    C_ST:     begin ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.mdr_en = 1'b1; end
                    C_MULDIV: begin ctl.zhi_out = 1'b1; ctl.hi_en = 1'b1; end
                    C_BR:     begin ctl.zlo_out = 1'b1; ctl.pc_en = con_ff; end
                    default: ;
                endcase
            end
            S_T7: begin
                case (w_cls)
                    C_LD: begin ctl.mdr_out = 1'b1; ctl.gra = 1'b1; ctl.rin = 1'b1; end
                    C_ST: ctl.write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Mini SRC hardwired control unit: state register and next-state logic.
// Build option SINGLE_STEP_EN adds a step input that gates every fetch.
//
// state   | meaning
// S_RESET | reset / post-reset hold, running=1, no strobes
// S_T0-T2 | instruction fetch
// S_T3-T7 | decode-dependent execute steps
// S_WAIT  | single-step gate before T0 (SINGLE_STEP_EN only)
// S_HALT  | stopped, running=0, left only through clr
module control_sequencer
    import src_ctrl_pkg::*;
#(
    parameter int RESET_PC_HOLD = 1
) (
    input  logic        clk,
    input  logic        clr,
`ifdef SINGLE_STEP_EN
    input  logic        step,
`endif
    input  logic [31:0] ir,
    input  logic        con_ff,
    input  logic        stop,
    output logic        gra,
    output logic        grb,
    output logic        grc,
    output logic        rin,
    output logic        rout,
    output logic        ba_out,
    output logic        pc_out,
    output logic        mdr_out,
    output logic        zhi_out,
    output logic        zlo_out,
    output logic        hi_out,
    output logic        lo_out,
    output logic        c_out,
    output logic        inport_out,
    output logic        pc_en,
    output logic        pc_inc,
    output logic        ir_en,
    output logic        mar_en,
    output logic        mdr_en,
    output logic        y_en,
    output logic        zhi_en,
    output logic        zlo_en,
    output logic        hi_en,
    output logic        lo_en,
    output logic        outport_en,
    output logic        con_in,
    output logic        read,
    output logic        write,
    output logic [4:0]  alu_control,
    output logic        running
);

    localparam int HOLD_W = $clog2(RESET_PC_HOLD + 1);

    state_t            r_state;
    state_t            w_next;
    state_t            w_boundary;
    logic [HOLD_W-1:0] r_hold;
    logic [4:0]        w_opcode;
    logic              w_step_rise;
    logic              w_ir_unused;
    ctrl_out_t         w_ctl;

    assign w_opcode    = ir[31:27];
    assign w_ir_unused = ^ir[26:0];

`ifdef SINGLE_STEP_EN
    logic r_step_d;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) r_step_d <= 1'b0;
        else      r_step_d <= step;
    end

    assign w_step_rise = step & ~r_step_d;
    assign w_boundary  = stop ? S_HALT : S_WAIT;
`else
    assign w_step_rise = 1'b0;
    assign w_boundary  = stop ? S_HALT : S_T0;
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= S_RESET;
            r_hold  <= HOLD_W'(RESET_PC_HOLD);
        end else begin
            r_state <= w_next;
            if (r_state == S_RESET && r_hold != '0)
                r_hold <= r_hold - HOLD_W'(1);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RESET: if (r_hold == '0) w_next = w_boundary;
            S_WAIT: begin
                if (stop)             w_next = S_HALT;
                else if (w_step_rise) w_next = S_T0;
            end
            S_T0: w_next = S_T1;
            S_T1: w_next = S_T2;
            S_T2: w_next = S_T3;
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                if (r_state == S_T3 && w_opcode == OP_HALT)
                    w_next = S_HALT;
                else if (r_state == last_step(op_class(w_opcode)))
                    w_next = w_boundary;
                else
                    w_next = state_t'(r_state + 4'd1);
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_HALT;
        endcase
    end

    ctrl_decode u_decode (
        .state  (r_state),
        .opcode (w_opcode),
        .con_ff (con_ff),
        .ctl    (w_ctl)
    );

    assign gra         = w_ctl.gra;
    assign grb         = w_ctl.grb;
    assign grc         = w_ctl.grc;
    assign rin         = w_ctl.rin;
    assign rout        = w_ctl.rout;
    assign ba_out      = w_ctl.ba_out;
    assign pc_out      = w_ctl.pc_out;
    assign mdr_out     = w_ctl.mdr_out;
    assign zhi_out     = w_ctl.zhi_out;
    assign zlo_out     = w_ctl.zlo_out;
    assign hi_out      = w_ctl.hi_out;
    assign lo_out      = w_ctl.lo_out;
    assign c_out       = w_ctl.c_out;
    assign inport_out  = w_ctl.inport_out;
    assign pc_en       = w_ctl.pc_en;
    assign pc_inc      = w_ctl.pc_inc;
    assign ir_en       = w_ctl.ir_en;
    assign mar_en      = w_ctl.mar_en;
    assign mdr_en      = w_ctl.mdr_en;
    assign y_en        = w_ctl.y_en;
    assign zhi_en      = w_ctl.zhi_en;
    assign zlo_en      = w_ctl.zlo_en;
    assign hi_en       = w_ctl.hi_en;
    assign lo_en       = w_ctl.lo_en;
    assign outport_en  = w_ctl.outport_en;
    assign con_in      = w_ctl.con_in;
    assign read        = w_ctl.read;
    assign write       = w_ctl.write;
    assign alu_control = w_ctl.alu_control;
    assign running     = w_ctl.running;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus pushes hand-written control
// words per cycle, a monitor pops and compares one per falling clock edge.
module tb_control_sequencer;

    typedef logic [33:0] vec_t;
    typedef struct {
        string nm;
        vec_t  v;
    } exp_t;

    localparam int   HOLD       = 1;
    localparam vec_t GRA        = vec_t'(1) << 0;
    localparam vec_t GRB        = vec_t'(1) << 1;
    localparam vec_t GRC        = vec_t'(1) << 2;
    localparam vec_t RIN        = vec_t'(1) << 3;
    localparam vec_t ROUT       = vec_t'(1) << 4;
    localparam vec_t BA_OUT     = vec_t'(1) << 5;
    localparam vec_t PC_OUT     = vec_t'(1) << 6;
    localparam vec_t MDR_OUT    = vec_t'(1) << 7;
    localparam vec_t ZHI_OUT    = vec_t'(1) << 8;
    localparam vec_t ZLO_OUT    = vec_t'(1) << 9;
    localparam vec_t HI_OUT     = vec_t'(1) << 10;
    localparam vec_t LO_OUT     = vec_t'(1) << 11;
    localparam vec_t C_OUT      = vec_t'(1) << 12;
    localparam vec_t INPORT_OUT = vec_t'(1) << 13;
    localparam vec_t PC_EN      = vec_t'(1) << 14;
    localparam vec_t PC_INC     = vec_t'(1) << 15;
    localparam vec_t IR_EN      = vec_t'(1) << 16;
    localparam vec_t MAR_EN     = vec_t'(1) << 17;
    localparam vec_t MDR_EN     = vec_t'(1) << 18;
    localparam vec_t Y_EN       = vec_t'(1) << 19;
    localparam vec_t ZHI_EN     = vec_t'(1) << 20;
    localparam vec_t ZLO_EN     = vec_t'(1) << 21;
    localparam vec_t HI_EN      = vec_t'(1) << 22;
    localparam vec_t LO_EN      = vec_t'(1) << 23;
    localparam vec_t OUTPORT_EN = vec_t'(1) << 24;
    localparam vec_t CON_IN     = vec_t'(1) << 25;
    localparam vec_t READ       = vec_t'(1) << 26;
    localparam vec_t WRITE      = vec_t'(1) << 27;
    localparam vec_t RUN        = vec_t'(1) << 33;
    localparam vec_t A_ADD      = vec_t'(3) << 28;
    localparam vec_t F0 = RUN | PC_OUT | MAR_EN | PC_INC | ZLO_EN | A_ADD;
    localparam vec_t F1 = RUN | ZLO_OUT | PC_EN | READ | MDR_EN;
    localparam vec_t F2 = RUN | MDR_OUT | IR_EN;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] ir = '0;
    logic        con_ff = 1'b0;
    logic        stop = 1'b0;
`ifdef SINGLE_STEP_EN
    logic        step = 1'b0;
`endif
    logic gra, grb, grc, rin, rout, ba_out, pc_out, mdr_out, zhi_out, zlo_out;
    logic hi_out, lo_out, c_out, inport_out, pc_en, pc_inc, ir_en, mar_en, mdr_en;
    logic y_en, zhi_en, zlo_en, hi_en, lo_en, outport_en, con_in, read, write, running;
    logic [4:0] alu_control;
    vec_t act;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    control_sequencer #(.RESET_PC_HOLD(HOLD)) dut (
        .clk(clk), .clr(clr),
`ifdef SINGLE_STEP_EN
        .step(step),
`endif
        .ir(ir), .con_ff(con_ff), .stop(stop),
        .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout), .ba_out(ba_out),
        .pc_out(pc_out), .mdr_out(mdr_out), .zhi_out(zhi_out), .zlo_out(zlo_out),
        .hi_out(hi_out), .lo_out(lo_out), .c_out(c_out), .inport_out(inport_out),
        .pc_en(pc_en), .pc_inc(pc_inc), .ir_en(ir_en), .mar_en(mar_en), .mdr_en(mdr_en),
        .y_en(y_en), .zhi_en(zhi_en), .zlo_en(zlo_en), .hi_en(hi_en), .lo_en(lo_en),
        .outport_en(outport_en), .con_in(con_in), .read(read), .write(write),
        .alu_control(alu_control), .running(running)
    );

    assign act = {running, alu_control, write, read, con_in, outport_en, lo_en, hi_en,
                  zlo_en, zhi_en, y_en, mdr_en, mar_en, ir_en, pc_inc, pc_en,
                  inport_out, c_out, lo_out, hi_out, zlo_out, zhi_out, mdr_out, pc_out,
                  ba_out, rout, rin, grc, grb, gra};

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            n_chk++;
            if (act === e.v) n_pass++;
            else $display("FAIL %s: got %h expected %h", e.nm, act, e.v);
        end
    end

    function automatic vec_t alu(input int op);
        return vec_t'(op) << 28;
    endfunction

    task automatic push(input string nm, input vec_t v);
        exp_t e;
        e.nm = nm;
        e.v  = v;
        q.push_back(e);
    endtask

    task automatic go(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Ends one cycle into the first T0 (or S_WAIT with single-step).
    task automatic do_reset(input int n);
        @(negedge clk);
        #2 clr = 1'b0;
        repeat (n) begin
            go(1);
            push("reset", RUN);
        end
        @(negedge clk);
        #2 clr = 1'b1;
        repeat (HOLD) begin
            go(1);
            push("reset hold", RUN);
        end
        go(1);
    endtask

    task automatic start(input string nm, input logic [31:0] ir_v, input logic con_v);
        ir     = ir_v;
        con_ff = con_v;
`ifdef SINGLE_STEP_EN
        step = 1'b1;
        push({nm, " wait"}, RUN);
        go(1);
        step = 1'b0;
`endif
        push({nm, " T0"}, F0);
        push({nm, " T1"}, F1);
        push({nm, " T2"}, F2);
    endtask

    task automatic rtype(input string nm, input logic [31:0] ir_v, input int op);
        start(nm, ir_v, 1'b0);
        push({nm, " T3"}, RUN | GRB | ROUT | Y_EN);
        push({nm, " T4"}, RUN | GRC | ROUT | alu(op) | ZLO_EN);
        push({nm, " T5"}, RUN | ZLO_OUT | GRA | RIN);
        go(6);
    endtask

    task automatic one_step(input string nm, input logic [31:0] ir_v, input vec_t t3);
        start(nm, ir_v, 1'b0);
        push({nm, " T3"}, t3);
        go(4);
    endtask

    initial begin
        do_reset(3);

        rtype("add", 32'h1891_8000, 3);

        start("ld", 32'h0080_0075, 1'b0);
        push("ld T3", RUN | GRB | ROUT | BA_OUT | Y_EN);
        push("ld T4", RUN | C_OUT | A_ADD | ZLO_EN);
        push("ld T5", RUN | ZLO_OUT | MAR_EN);
        push("ld T6", RUN | READ | MDR_EN);
        push("ld T7", RUN | MDR_OUT | GRA | RIN);
        go(8);

        start("st", 32'h1080_0010, 1'b0);
        push("st T3", RUN | GRB | ROUT | BA_OUT | Y_EN);
        push("st T4", RUN | C_OUT | A_ADD | ZLO_EN);
        push("st T5", RUN | ZLO_OUT | MAR_EN);
        push("st T6", RUN | GRA | ROUT | MDR_EN);
        push("st T7", RUN | WRITE);
        go(8);

        start("ldi", 32'h0880_0005, 1'b0);
        push("ldi T3", RUN | GRB | ROUT | BA_OUT | Y_EN);
        push("ldi T4", RUN | C_OUT | A_ADD | ZLO_EN);
        push("ldi T5", RUN | ZLO_OUT | GRA | RIN);
        go(6);

        rtype("sub", 32'h2000_0000, 4);
        rtype("rol", 32'h5800_0000, 11);

        start("andi", 32'h6800_0000, 1'b0);
        push("andi T3", RUN | GRB | ROUT | Y_EN);
        push("andi T4", RUN | C_OUT | alu(5) | ZLO_EN);
        push("andi T5", RUN | ZLO_OUT | GRA | RIN);
        go(6);

        start("neg", 32'h8800_0000, 1'b0);
        push("neg T3", RUN | GRB | ROUT | alu(17) | ZLO_EN);
        push("neg T4", RUN | ZLO_OUT | GRA | RIN);
        go(5);

        start("mul", 32'h7800_0000, 1'b0);
        push("mul T3", RUN | GRA | ROUT | Y_EN);
        push("mul T4", RUN | GRB | ROUT | alu(15) | ZLO_EN | ZHI_EN);
        push("mul T5", RUN | ZLO_OUT | LO_EN);
        push("mul T6", RUN | ZHI_OUT | HI_EN);
        go(7);

        for (int c = 0; c < 2; c++) begin
            start($sformatf("br con=%0d", c), 32'h9800_0000, c[0]);
            push("br T3", RUN | GRA | ROUT | CON_IN);
            push("br T4", RUN | PC_OUT | Y_EN);
            push("br T5", RUN | C_OUT | A_ADD | ZLO_EN);
            push($sformatf("br con=%0d T6", c), RUN | ZLO_OUT | (c == 1 ? PC_EN : '0));
            go(7);
        end

        one_step("jr", 32'hA000_0000, RUN | GRA | ROUT | PC_EN);

        start("jal", 32'hA800_0000, 1'b0);
        push("jal T3", RUN | PC_OUT | GRB | RIN);
        push("jal T4", RUN | GRA | ROUT | PC_EN);
        go(5);

        one_step("in",    32'hB000_0000, RUN | INPORT_OUT | GRA | RIN);
        one_step("out",   32'hB800_0000, RUN | GRA | ROUT | OUTPORT_EN);
        one_step("mfhi",  32'hC000_0000, RUN | HI_OUT | GRA | RIN);
        one_step("mflo",  32'hC800_0000, RUN | LO_OUT | GRA | RIN);
        one_step("nop",   32'hD000_0000, RUN);
        one_step("undef", 32'hF000_0000, RUN);

        // Abort an add in T4 with a 3-cycle reset, then confirm a clean restart.
        start("add abort", 32'h1891_8000, 1'b0);
        push("add abort T3", RUN | GRB | ROUT | Y_EN);
        push("add abort T4", RUN | GRC | ROUT | A_ADD | ZLO_EN);
        go(4);
        do_reset(3);
        rtype("add after reset", 32'h1891_8000, 3);

        // stop raised during T2: the add completes, then the unit halts.
        start("add stop", 32'h1891_8000, 1'b0);
        push("add stop T3", RUN | GRB | ROUT | Y_EN);
        push("add stop T4", RUN | GRC | ROUT | A_ADD | ZLO_EN);
        push("add stop T5", RUN | ZLO_OUT | GRA | RIN);
        go(2);
        stop = 1'b1;
        go(4);
        for (int i = 0; i < 20; i++) push($sformatf("halted %0d", i), '0);
        go(20);
        stop = 1'b0;
        do_reset(2);

        start("halt", 32'hD800_0000, 1'b0);
        push("halt T3", RUN);
        for (int i = 0; i < 5; i++) push($sformatf("halt op %0d", i), '0);
        go(9);
        do_reset(1);

        one_step("nop after halt", 32'hD000_0000, RUN);
        push("next fetch", F0);
        go(2);

        n_chk++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL scoreboard drain: got %0d left expected 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired Mini SRC control unit that sequences the 32-bit bus datapath through fetch, decode and execute.
- Reads IR and the CON flip-flop result; drives every register enable, bus-out select, memory strobe and ALU opcode.
- Sits beside the datapath at the top level and replaces testbench-driven control signals.

Parameters:
- RESET_PC_HOLD, 1, number of cycles held in S_RESET after clr deasserts before the first fetch (minimum 1).

Ports:
- clk  in  1  system clock; all state advances on the rising edge.
- clr  in  1  reset, asynchronous, active-low.
- ir  in  32  current instruction register contents; opcode is ir[31:27].
- con_ff  in  1  branch condition result from the CON FF.
- stop  in  1  level request to halt at the next instruction boundary.
- gra, grb, grc, rin, rout, ba_out  out  1 each  select-encoder controls.
- pc_out, mdr_out, zhi_out, zlo_out, hi_out, lo_out, c_out, inport_out  out  1 each  bus source selects (one-hot or none).
- pc_en, pc_inc, ir_en, mar_en, mdr_en, y_en, zhi_en, zlo_en, hi_en, lo_en, outport_en, con_in  out  1 each  register load enables.
- read, write  out  1 each  memory strobes.
- alu_control  out  5  ALU operation select.
- running  out  1  high except in S_HALT.

Behaviour:
- Reset: while clr=0, state is S_RESET and all outputs are 0 except running=1. Reset mid-instruction aborts the instruction immediately.
- Outputs are Moore: a pure function of the state register, plus ir/con_ff for decode-dependent steps. Every output is 0 unless listed for the current step.
- At most one bus source is high in any cycle.
- Fetch:
  - T0: pc_out, mar_en, pc_inc, zlo_en, alu_control=ADD.
  - T1: zlo_out, pc_en, read, mdr_en.
  - T2: mdr_out, ir_en.
- T3 decodes ir[31:27] as follows:
  - R-type (add, sub, and, or, shr, shra, shl, ror, rol):
    - T3: grb, rout, y_en.
    - T4: grc, rout, alu_control=op, zlo_en.
    - T5: zlo_out, gra, rin.
    - Total 6 cycles.
  - neg, not:
    - T3: grb, rout, alu_control=op, zlo_en.
    - T4: zlo_out, gra, rin.
  - I-type (addi, andi, ori): as R-type, but T4 uses c_out instead of grc/rout.
  - ldi:
    - T3: grb, rout, ba_out, y_en.
    - T4: c_out, ADD, zlo_en.
    - T5: zlo_out, gra, rin.
  - ld:
    - As ldi through T4.
    - T5: zlo_out, mar_en.
    - T6: read, mdr_en.
    - T7: mdr_out, gra, rin.
    - Total 8 cycles.
  - st:
    - As ld through T5.
    - T6: gra, rout, mdr_en (read=0).
    - T7: write.
  - mul, div:
    - T3: gra, rout, y_en.
    - T4: grb, rout, op, zlo_en, zhi_en.
    - T5: zlo_out, lo_en.
    - T6: zhi_out, hi_en.
  - br:
    - T3: gra, rout, con_in.
    - T4: pc_out, y_en.
    - T5: c_out, ADD, zlo_en.
    - T6: zlo_out, and pc_en only if con_ff=1. Not-taken still spends T6.
  - jr: T3: gra, rout, pc_en.
  - jal:
    - T3: pc_out, grb, rin.
    - T4: gra, rout, pc_en.
  - in: T3: inport_out, gra, rin.
  - out: T3: gra, rout, outport_en.
  - mfhi / mflo: T3: hi_out / lo_out, gra, rin.
  - nop: no T3 actions; returns to T0.
  - halt: enter S_HALT. Undefined opcodes behave as nop.
- Instruction boundaries:
  - The last execute step of each instruction returns to T0.
  - If stop=1 when T0 would be entered, go to S_HALT instead.
- S_HALT: all outputs 0, running=0. Exit only via clr.

Optional Feature:
- SINGLE_STEP_EN defined: adds input port step (1 bit). The FSM waits in S_WAIT with all outputs 0 before each T0 and proceeds on the cycle after a rising edge of step. stop is still honoured from S_WAIT.
- SINGLE_STEP_EN undefined: no step port; T0 follows directly.

Decomposition:
- Package src_ctrl_pkg holds:
  - 5-bit opcode constants: ld=0, ldi=1, st=2, add=3, sub=4, and=5, or=6, shr=7, shra=8, shl=9, ror=10, rol=11, addi=12, andi=13, ori=14, mul=15, div=16, neg=17, not=18, br=19, jr=20, jal=21, in=22, out=23, mfhi=24, mflo=25, nop=26, halt=27.
  - ALU op constants, numerically equal to the opcodes (addi/andi/ori map to add/and/or).
  - The state enum.
- One sub-module, ctrl_decode: combinational, maps (state, opcode, con_ff) to the output bundle. The parent holds only the state register and next-state logic.

Test Plan:
- Hold clr=0 for 3 cycles mid-T4 of an add, then release → all strobes 0 during reset; fetch T0 starts RESET_PC_HOLD+1 cycles after release.
- ir=0x18918000 (add r1,r2,r3) → T3 grb+rout+y_en, T4 alu_control=3 with zlo_en, T5 zlo_out+gra+rin; next T0 exactly 6 cycles after the previous T0.
- ir=0x00800075 (ld r1,0x75(r0)) → ba_out=1 in T3; read+mdr_en in T6; gra+rin in T7; 8-cycle instruction.
- br with con_ff=0, then br with con_ff=1 → pc_en in T6 only on the second; both instructions take 7 cycles.
- stop=1 asserted during T2 of an add → add completes, then running=0 and all outputs stay 0 for 20 cycles.
- ir opcode 27 (halt) → S_HALT in cycle T3. With SINGLE_STEP_EN, one step pulse advances exactly one instruction.
